// File: rtl/rvfi_retire_counters.sv
// Retirement-event counters fed by the minrv32 RVFI port, with an atomic
// snapshot into a shadow bank that is read one counter at a time.
//
// Parameters:
//   CNT_W  counter and rd_data width (8..64)
//   SAT    0: counters wrap; 1: counters saturate at all-ones
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   rvfi_*              retirement stream (valid, order, insn, trap, masks)
//   snap_req            copy live counters into the shadow bank
//   clr_req             zero the live counters (same-cycle events are kept)
//   rd_req, rd_sel      shadow read request; sel 0 instret, 1 load, 2 store,
//                       3 long insn, 4 trap, 5..7 read as zero
//   rd_ack, rd_data     one-cycle response, one cycle after rd_req
//   order_err           sticky rvfi_order discontinuity flag
// Optional feature macro: RVFI_ORDER_CHECK_EN enables the order checker;
// without it order_err is tied low and rvfi_order is ignored.
module rvfi_retire_counters #(
    parameter int CNT_W = 32,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rvfi_valid,
    input  logic [63:0]      rvfi_order,
    input  logic [31:0]      rvfi_insn,
    input  logic             rvfi_trap,
    input  logic [3:0]       rvfi_mem_rmask,
    input  logic [3:0]       rvfi_mem_wmask,
    input  logic             snap_req,
    input  logic             clr_req,
    input  logic             rd_req,
    input  logic [2:0]       rd_sel,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             order_err
);

    localparam int NCNT = 5;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] live   [NCNT];
    logic [CNT_W-1:0] shadow [NCNT];
    logic [NCNT-1:0]  ev;
    logic [2:0]       sel;
    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] shadow_sel;

    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] base,
        input logic             inc
    );
        logic [CNT_W-1:0] r;
        r = base;
        if (inc && !((SAT != 0) && (&base))) begin
            r = base + CNT_W'(1);
        end
        return r;
    endfunction

    always_comb begin
        ev    = '0;
        ev[0] = rvfi_valid;
        ev[1] = rvfi_valid && (|rvfi_mem_rmask);
        ev[2] = rvfi_valid && (|rvfi_mem_wmask);
        ev[3] = rvfi_valid && (rvfi_insn[1:0] == 2'b11);
        ev[4] = rvfi_valid && rvfi_trap;
    end

    // Shadow captures the pre-update live values; a clear restarts the
    // count from zero but still keeps this cycle's events.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCNT; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (snap_req) begin
                    shadow[i] <= live[i];
                end
                live[i] <= bump(clr_req ? '0 : live[i], ev[i]);
            end
        end
    end

    always_comb begin
        shadow_sel = '0;
        case (sel)
            3'd0:    shadow_sel = shadow[0];
            3'd1:    shadow_sel = shadow[1];
            3'd2:    shadow_sel = shadow[2];
            3'd3:    shadow_sel = shadow[3];
            3'd4:    shadow_sel = shadow[4];
            default: shadow_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && rd_req) begin
                sel <= rd_sel;
            end
            if (state == RESP) begin
                hold <= shadow_sel;
            end
        end
    end

    // A reset landing on the response cycle suppresses the ack.
    always_comb begin
        state_next = state;
        rd_ack     = 1'b0;
        rd_data    = hold;
        unique case (state)
            IDLE: begin
                if (rd_req) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                if (!reset) begin
                    rd_ack  = 1'b1;
                    rd_data = shadow_sel;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RVFI_ORDER_CHECK_EN
    logic        armed;
    logic [63:0] exp_order;
    logic        err;
    logic        unused_bits;

    assign unused_bits = ^rvfi_insn[31:2];

    // A clear together with a valid re-arms from that valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed     <= 1'b0;
            exp_order <= '0;
            err       <= 1'b0;
        end else if (rvfi_valid) begin
            armed     <= 1'b1;
            exp_order <= rvfi_order + 64'd1;
            if (clr_req) begin
                err <= 1'b0;
            end else if (armed && rvfi_order != exp_order) begin
                err <= 1'b1;
            end
        end else if (clr_req) begin
            armed <= 1'b0;
            err   <= 1'b0;
        end
    end

    assign order_err = err;
`else
    logic unused_bits;

    assign unused_bits = ^{rvfi_order, rvfi_insn[31:2]};
    assign order_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_counters.sv
// Bench for rvfi_retire_counters: a wrapping and a saturating 8-bit
// instance share one stimulus stream and are checked against a model.
module tb_rvfi_retire_counters;

    localparam int W = 8;
    localparam int MAXV = 255;
`ifdef RVFI_ORDER_CHECK_EN
    localparam bit ORD_EN = 1'b1;
`else
    localparam bit ORD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         rvfi_valid;
    logic [63:0]  rvfi_order;
    logic [31:0]  rvfi_insn;
    logic         rvfi_trap;
    logic [3:0]   rvfi_mem_rmask;
    logic [3:0]   rvfi_mem_wmask;
    logic         snap_req;
    logic         clr_req;
    logic         rd_req;
    logic [2:0]   rd_sel;
    logic         ack_w, ack_s, err_w, err_s;
    logic [W-1:0] data_w, data_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rvfi_retire_counters #(.CNT_W(W), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .rvfi_valid(rvfi_valid),
        .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .snap_req(snap_req),
        .clr_req(clr_req), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(ack_w), .rd_data(data_w), .order_err(err_w)
    );

    rvfi_retire_counters #(.CNT_W(W), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .rvfi_valid(rvfi_valid),
        .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .snap_req(snap_req),
        .clr_req(clr_req), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(ack_s), .rd_data(data_s), .order_err(err_s)
    );

    // Reference model: event counts as plain integers.
    int          lw[5], ls[5], sw[5], ss[5];
    bit          m_resp;
    int          m_sel;
    int          hold_w, hold_s;
    bit          m_armed;
    logic [63:0] m_exp;
    bit          m_err;

    function automatic int shv_w(int s);
        return (s < 5) ? sw[s] : 0;
    endfunction

    function automatic int shv_s(int s);
        return (s < 5) ? ss[s] : 0;
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit e[5];
        int b;
        e[0] = rvfi_valid;
        e[1] = rvfi_valid && (rvfi_mem_rmask != 0);
        e[2] = rvfi_valid && (rvfi_mem_wmask != 0);
        e[3] = rvfi_valid && (rvfi_insn[1:0] == 2'b11);
        e[4] = rvfi_valid && rvfi_trap;
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                lw[i] = 0; ls[i] = 0; sw[i] = 0; ss[i] = 0;
            end
            m_resp = 0; m_sel = 0; hold_w = 0; hold_s = 0;
            m_armed = 0; m_exp = 0; m_err = 0;
        end else begin
            if (m_resp) begin
                hold_w = shv_w(m_sel);
                hold_s = shv_s(m_sel);
                m_resp = 0;
            end else if (rd_req) begin
                m_resp = 1;
                m_sel  = int'(rd_sel);
            end
            if (snap_req) begin
                for (int i = 0; i < 5; i++) begin
                    sw[i] = lw[i];
                    ss[i] = ls[i];
                end
            end
            for (int i = 0; i < 5; i++) begin
                b = clr_req ? 0 : lw[i];
                if (e[i]) b = (b + 1) % (MAXV + 1);
                lw[i] = b;
                b = clr_req ? 0 : ls[i];
                if (e[i] && b < MAXV) b = b + 1;
                ls[i] = b;
            end
            if (ORD_EN) begin
                if (rvfi_valid) begin
                    if (clr_req) m_err = 0;
                    else if (m_armed && rvfi_order != m_exp) m_err = 1;
                    m_armed = 1;
                    m_exp   = rvfi_order + 64'd1;
                end else if (clr_req) begin
                    m_armed = 0;
                    m_err   = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit a;
        a = m_resp && !reset;
        check("ack_wrap", ack_w, a);
        check("ack_sat", ack_s, a);
        check("data_wrap", data_w, a ? shv_w(m_sel) : hold_w);
        check("data_sat", data_s, a ? shv_s(m_sel) : hold_s);
        check("oerr_wrap", err_w, m_err);
        check("oerr_sat", err_s, m_err);
    end

    logic [63:0] ord = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rvfi_valid = 0; rvfi_trap = 0;
        rvfi_mem_rmask = 0; rvfi_mem_wmask = 0;
        snap_req = 0; clr_req = 0; rd_req = 0;
    endtask

    task automatic retire(input logic [3:0] rm, input logic [3:0] wm,
                          input logic [31:0] insn, input logic trap);
        rvfi_valid = 1; rvfi_mem_rmask = rm; rvfi_mem_wmask = wm;
        rvfi_insn = insn; rvfi_trap = trap; rvfi_order = ord;
        ord = ord + 1;
        tick();
        idle();
    endtask

    task automatic pulse_snap();
        snap_req = 1;
        tick();
        snap_req = 0;
    endtask

    task automatic pulse_clr();
        clr_req = 1;
        tick();
        clr_req = 0;
    endtask

    task automatic read_lit(input int sel, input int ew, input int es);
        rd_req = 1;
        rd_sel = 3'(sel);
        tick();
        rd_req = 0;
        @(negedge clk);
        check("lit_ack", ack_w, 1);
        check("lit_wrap", data_w, ew);
        check("lit_sat", data_s, es);
        tick();
    endtask

    initial begin
        reset = 1; rvfi_order = 0; rvfi_insn = 0; rd_sel = 0;
        idle();
        tick(); tick();
        reset = 0;
        tick();
        read_lit(0, 0, 0);

        // three retires: load, store, plain; all 32-bit encodings
        retire(4'h1, 4'h0, 32'h0000_0013, 0);
        retire(4'h0, 4'hF, 32'h0000_0023, 0);
        retire(4'h0, 4'h0, 32'h0000_0033, 0);
        pulse_snap();
        read_lit(0, 3, 3);
        read_lit(1, 1, 1);
        read_lit(2, 1, 1);
        read_lit(3, 3, 3);

        // 257 retires: wrap gives 1, saturate gives 255
        pulse_clr();
        for (int i = 0; i < 257; i++) begin
            retire(4'($urandom), 4'($urandom), $urandom, 0);
        end
        pulse_snap();
        read_lit(0, 1, MAXV);

        // trap, clear and snap in one cycle
        clr_req = 1; snap_req = 1;
        retire(4'h0, 4'h0, 32'h0000_0013, 1);
        read_lit(4, 0, 0);
        pulse_snap();
        read_lit(4, 1, 1);

        // response latency and ignored back-to-back request
        rd_req = 1; rd_sel = 0;
        tick();
        @(negedge clk);
        check("lat_ack", ack_w, 1);
        tick();
        rd_req = 0;
        @(negedge clk);
        check("noq_ack", ack_w, 0);
        tick();
        read_lit(6, 0, 0);

        // order discontinuity
        pulse_clr();
        ord = 0;
        retire(4'h0, 4'h0, 32'h13, 0);
        retire(4'h0, 4'h0, 32'h13, 0);
        retire(4'h0, 4'h0, 32'h13, 0);
        ord = 4;
        retire(4'h0, 4'h0, 32'h13, 0);
        @(negedge clk);
        check("oerr_set", err_w, ORD_EN);
        tick(); tick(); tick();
        @(negedge clk);
        check("oerr_sticky", err_s, ORD_EN);
        tick();
        pulse_clr();
        @(negedge clk);
        check("oerr_clr", err_w, 0);
        tick();

        // reset on the response cycle
        pulse_snap();
        rd_req = 1; rd_sel = 0;
        tick();
        rd_req = 0; reset = 1;
        @(negedge clk);
        check("rst_ack", ack_w, 0);
        tick();
        reset = 0;
        pulse_snap();
        for (int s = 0; s < 5; s++) read_lit(s, 0, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rvfi_valid = ($urandom % 4) != 0;
            if ($urandom % 16 == 0) ord = ord + 64'($urandom % 3);
            rvfi_order = ord;
            if (rvfi_valid) ord = ord + 1;
            rvfi_insn = $urandom;
            rvfi_trap = ($urandom % 8) == 0;
            rvfi_mem_rmask = ($urandom % 2) ? 4'($urandom) : 4'h0;
            rvfi_mem_wmask = ($urandom % 2) ? 4'($urandom) : 4'h0;
            snap_req = ($urandom % 16) == 0;
            clr_req = ($urandom % 64) == 0;
            rd_req = ($urandom % 4) == 0;
            rd_sel = 3'($urandom);
            reset = ($urandom % 500) == 0;
            tick();
        end
        reset = 0;
        idle();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
